// File: rtl/rs_alu_pkg.sv
// Shared widths, op codes and small helpers for the ALU reservation station.
package rs_alu_pkg;
  localparam int ROBBW   = 5;
  localparam int RS_SIZE = 16;
  localparam int RS_BW   = 4;

  typedef logic [ROBBW-1:0] rob_t;
  typedef logic [31:0]      word_t;
  typedef logic [5:0]       op_t;

  localparam op_t OP_ADD  = 6'h01;
  localparam op_t OP_SUB  = 6'h02;
  localparam op_t OP_ADDI = 6'h0A;
  localparam op_t OP_BEQ  = 6'h14;
  localparam op_t OP_JAL  = 6'h1E;

  function automatic logic cdb_hit(input logic flag, input rob_t tag, input rob_t q);
    return flag && (tag == q);
  endfunction
endpackage

// File: rtl/rs_alu_if.sv
// Issue, CDB snoop and dispatch buses of the ALU reservation station.
interface rs_alu_if;
  import rs_alu_pkg::*;

  logic  issue_flag;
  op_t   issue_code;
  rob_t  issue_Q1, issue_Q2;
  logic  issue_Q1v, issue_Q2v;
  word_t issue_V1, issue_V2, issue_A, issue_pc;
  rob_t  issue_rob_id;
  logic  rs_full;

  logic  alu_cdb_flag, lsb_cdb_flag;
  rob_t  alu_cdb_rob_id, lsb_cdb_rob_id;
  word_t alu_cdb_res, lsb_cdb_res;

  logic  out_flag;
  word_t out_V1, out_V2, out_A, out_pc;
  op_t   out_code;
  rob_t  out_rob_id;

  modport slave (
    input  issue_flag, issue_code, issue_Q1, issue_Q2, issue_Q1v, issue_Q2v,
           issue_V1, issue_V2, issue_A, issue_pc, issue_rob_id,
           alu_cdb_flag, alu_cdb_rob_id, alu_cdb_res,
           lsb_cdb_flag, lsb_cdb_rob_id, lsb_cdb_res,
    output rs_full, out_flag, out_V1, out_V2, out_A, out_pc, out_code, out_rob_id
  );

  modport master (
    output issue_flag, issue_code, issue_Q1, issue_Q2, issue_Q1v, issue_Q2v,
           issue_V1, issue_V2, issue_A, issue_pc, issue_rob_id,
           alu_cdb_flag, alu_cdb_rob_id, alu_cdb_res,
           lsb_cdb_flag, lsb_cdb_rob_id, lsb_cdb_res,
    input  rs_full, out_flag, out_V1, out_V2, out_A, out_pc, out_code, out_rob_id
  );
endinterface

// File: rtl/rs_prio_enc.sv
// Lowest-set-bit priority encoder.
module rs_prio_enc #(
  parameter int N = 16,
  parameter int W = 4
) (
  input  logic [N-1:0] vec,
  output logic         found,
  output logic [W-1:0] idx
);
  always_comb begin
    found = |vec;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--)
      if (vec[i]) idx = W'(i);
  end
endmodule

// File: rtl/rs_alu.sv
// ALU reservation station: holds issued ops until operands resolve via CDB
// snooping, then dispatches the lowest-index ready entry each cycle.
module rs_alu
  import rs_alu_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  logic     rdy,
  input  logic     rollback,
  rs_alu_if.slave  bus
);
  logic [RS_SIZE-1:0] busy, q1v, q2v, ready, hit1, hit2;
  op_t   code [RS_SIZE];
  word_t v1 [RS_SIZE], v2 [RS_SIZE], a [RS_SIZE], pc [RS_SIZE];
  word_t cap1 [RS_SIZE], cap2 [RS_SIZE];
  rob_t  q1 [RS_SIZE], q2 [RS_SIZE], rob [RS_SIZE];

  logic             free_found, disp_found, do_issue;
  logic [RS_BW-1:0] free_idx, disp_idx;
  logic             iss_q1v, iss_q2v;
  word_t            iss_v1, iss_v2;

  logic  o_flag;
  word_t o_v1, o_v2, o_a, o_pc;
  op_t   o_code;
  rob_t  o_rob;

  // ALU CDB takes precedence over LSB CDB on a (non-legal) double match.
  for (genvar i = 0; i < RS_SIZE; i++) begin : g_snoop
    logic am1, lm1, am2, lm2;
    assign am1     = cdb_hit(bus.alu_cdb_flag, bus.alu_cdb_rob_id, q1[i]);
    assign lm1     = cdb_hit(bus.lsb_cdb_flag, bus.lsb_cdb_rob_id, q1[i]);
    assign am2     = cdb_hit(bus.alu_cdb_flag, bus.alu_cdb_rob_id, q2[i]);
    assign lm2     = cdb_hit(bus.lsb_cdb_flag, bus.lsb_cdb_rob_id, q2[i]);
    assign hit1[i] = busy[i] & q1v[i] & (am1 | lm1);
    assign hit2[i] = busy[i] & q2v[i] & (am2 | lm2);
    assign cap1[i] = am1 ? bus.alu_cdb_res : bus.lsb_cdb_res;
    assign cap2[i] = am2 ? bus.alu_cdb_res : bus.lsb_cdb_res;
  end

  always_comb begin
    iss_q1v = bus.issue_Q1v;
    iss_v1  = bus.issue_V1;
    iss_q2v = bus.issue_Q2v;
    iss_v2  = bus.issue_V2;
    if (bus.issue_Q1v) begin
      if (cdb_hit(bus.alu_cdb_flag, bus.alu_cdb_rob_id, bus.issue_Q1)) begin
        iss_q1v = 1'b0; iss_v1 = bus.alu_cdb_res;
      end else if (cdb_hit(bus.lsb_cdb_flag, bus.lsb_cdb_rob_id, bus.issue_Q1)) begin
        iss_q1v = 1'b0; iss_v1 = bus.lsb_cdb_res;
      end
    end
    if (bus.issue_Q2v) begin
      if (cdb_hit(bus.alu_cdb_flag, bus.alu_cdb_rob_id, bus.issue_Q2)) begin
        iss_q2v = 1'b0; iss_v2 = bus.alu_cdb_res;
      end else if (cdb_hit(bus.lsb_cdb_flag, bus.lsb_cdb_rob_id, bus.issue_Q2)) begin
        iss_q2v = 1'b0; iss_v2 = bus.lsb_cdb_res;
      end
    end
  end

  assign ready = busy & ~q1v & ~q2v;

  // Free-slot search sees pre-dispatch busy, so a just-freed slot is reused next cycle.
  rs_prio_enc #(.N(RS_SIZE), .W(RS_BW)) u_free (.vec(~busy), .found(free_found), .idx(free_idx));
  rs_prio_enc #(.N(RS_SIZE), .W(RS_BW)) u_disp (.vec(ready),  .found(disp_found), .idx(disp_idx));

  assign do_issue    = bus.issue_flag & free_found;
  assign bus.rs_full = &busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy   <= '0;
      q1v    <= '0;
      q2v    <= '0;
      o_flag <= 1'b0;
      o_v1   <= '0;
      o_v2   <= '0;
      o_a    <= '0;
      o_pc   <= '0;
      o_code <= '0;
      o_rob  <= '0;
    end else if (!rdy) begin
      o_flag <= 1'b0;
    end else if (rollback) begin
      busy   <= '0;
      o_flag <= 1'b0;
    end else begin
      q1v    <= q1v & ~hit1;
      q2v    <= q2v & ~hit2;
      o_flag <= disp_found;
      if (disp_found) begin
        busy[disp_idx] <= 1'b0;
        o_v1   <= v1[disp_idx];
        o_v2   <= v2[disp_idx];
        o_a    <= a[disp_idx];
        o_pc   <= pc[disp_idx];
        o_code <= code[disp_idx];
        o_rob  <= rob[disp_idx];
      end
      if (do_issue) begin
        busy[free_idx] <= 1'b1;
        q1v[free_idx]  <= iss_q1v;
        q2v[free_idx]  <= iss_q2v;
      end
    end
  end

  // Payload carries no reset; validity is tracked by busy/q1v/q2v.
  always_ff @(posedge clk) begin
    if (rdy && !rollback) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (hit1[i]) v1[i] <= cap1[i];
        if (hit2[i]) v2[i] <= cap2[i];
      end
      if (do_issue) begin
        code[free_idx] <= bus.issue_code;
        v1[free_idx]   <= iss_v1;
        v2[free_idx]   <= iss_v2;
        q1[free_idx]   <= bus.issue_Q1;
        q2[free_idx]   <= bus.issue_Q2;
        a[free_idx]    <= bus.issue_A;
        pc[free_idx]   <= bus.issue_pc;
        rob[free_idx]  <= bus.issue_rob_id;
      end
    end
  end

  assign bus.out_flag   = o_flag;
  assign bus.out_V1     = o_v1;
  assign bus.out_V2     = o_v2;
  assign bus.out_A      = o_a;
  assign bus.out_pc     = o_pc;
  assign bus.out_code   = o_code;
  assign bus.out_rob_id = o_rob;
endmodule

// File: tb/tb_rs_alu.sv
// Directed-vector bench for rs_alu with hand-computed expectations.
module tb_rs_alu;
  import rs_alu_pkg::*;

  logic clk, rst_n, rdy, rollback;
  int   n_cmp, n_err;
  int   seen;

  rs_alu_if bus ();

  rs_alu dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rdy      (rdy),
    .rollback (rollback),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk)
    if (rst_n && rdy && !rollback && bus.issue_flag)
      assert (!bus.rs_full) else $error("issue asserted while rs_full");

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    bus.issue_flag = 1'b0; bus.issue_code = '0;
    bus.issue_Q1 = '0; bus.issue_Q2 = '0; bus.issue_Q1v = 1'b0; bus.issue_Q2v = 1'b0;
    bus.issue_V1 = '0; bus.issue_V2 = '0; bus.issue_A = '0; bus.issue_pc = '0;
    bus.issue_rob_id = '0;
    bus.alu_cdb_flag = 1'b0; bus.alu_cdb_rob_id = '0; bus.alu_cdb_res = '0;
    bus.lsb_cdb_flag = 1'b0; bus.lsb_cdb_rob_id = '0; bus.lsb_cdb_res = '0;
  endtask

  task automatic set_issue(input op_t c, input logic q1v_i, input rob_t q1_i, input word_t v1_i,
                           input logic q2v_i, input rob_t q2_i, input word_t v2_i,
                           input word_t a_i, input rob_t rob_i);
    bus.issue_flag = 1'b1; bus.issue_code = c;
    bus.issue_Q1v = q1v_i; bus.issue_Q1 = q1_i; bus.issue_V1 = v1_i;
    bus.issue_Q2v = q2v_i; bus.issue_Q2 = q2_i; bus.issue_V2 = v2_i;
    bus.issue_A = a_i; bus.issue_pc = 32'h1000 + 32'(rob_i); bus.issue_rob_id = rob_i;
  endtask

  task automatic issue_op(input op_t c, input logic q1v_i, input rob_t q1_i, input word_t v1_i,
                          input logic q2v_i, input rob_t q2_i, input word_t v2_i,
                          input word_t a_i, input rob_t rob_i);
    set_issue(c, q1v_i, q1_i, v1_i, q2v_i, q2_i, v2_i, a_i, rob_i);
    step();
    bus.issue_flag = 1'b0;
  endtask

  task automatic alu_cdb(input rob_t tag, input word_t res);
    bus.alu_cdb_flag = 1'b1; bus.alu_cdb_rob_id = tag; bus.alu_cdb_res = res;
    step();
    bus.alu_cdb_flag = 1'b0;
  endtask

  task automatic flush();
    rollback = 1'b1;
    step();
    rollback = 1'b0;
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    rst_n = 1'b0; rdy = 1'b1; rollback = 1'b0;
    clr_in();
    #2;
    chk("rst_out_flag", 32'(bus.out_flag), 32'd0);
    chk("rst_rs_full",  32'(bus.rs_full), 32'd0);
    chk("rst_out_V1",   bus.out_V1, 32'd0);
    chk("rst_out_rob",  32'(bus.out_rob_id), 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // Both operands ready: dispatched on the edge after the issue edge.
    issue_op(OP_ADD, 1'b0, 5'd0, 32'd5, 1'b0, 5'd0, 32'd7, 32'd0, 5'd3);
    chk("add_not_yet", 32'(bus.out_flag), 32'd0);
    step();
    chk("add_flag", 32'(bus.out_flag), 32'd1);
    chk("add_code", 32'(bus.out_code), 32'(OP_ADD));
    chk("add_V1",   bus.out_V1, 32'd5);
    chk("add_V2",   bus.out_V2, 32'd7);
    chk("add_rob",  32'(bus.out_rob_id), 32'd3);
    chk("add_pc",   bus.out_pc, 32'h1003);
    step();
    chk("add_flag_drop", 32'(bus.out_flag), 32'd0);

    // Pending Q1 woken by the ALU CDB three cycles later.
    issue_op(OP_ADDI, 1'b1, 5'd6, 32'd0, 1'b0, 5'd0, 32'd2, 32'd1, 5'd4);
    step(); step(); step();
    chk("addi_wait", 32'(bus.out_flag), 32'd0);
    alu_cdb(5'd6, 32'h10);
    chk("addi_capture_cycle", 32'(bus.out_flag), 32'd0);
    step();
    chk("addi_flag", 32'(bus.out_flag), 32'd1);
    chk("addi_V1",   bus.out_V1, 32'h10);
    chk("addi_A",    bus.out_A, 32'd1);
    chk("addi_code", 32'(bus.out_code), 32'(OP_ADDI));

    // Same-cycle forwarding from the LSB CDB at issue.
    set_issue(OP_SUB, 1'b0, 5'd0, 32'd9, 1'b1, 5'd2, 32'd0, 32'd0, 5'd5);
    bus.lsb_cdb_flag = 1'b1; bus.lsb_cdb_rob_id = 5'd2; bus.lsb_cdb_res = 32'hABCD;
    step();
    clr_in();
    step();
    chk("fwd_flag", 32'(bus.out_flag), 32'd1);
    chk("fwd_V2",   bus.out_V2, 32'hABCD);
    chk("fwd_rob",  32'(bus.out_rob_id), 32'd5);
    step();

    // Fill all entries with pending tags 16+i, rob i.
    for (int i = 0; i < RS_SIZE; i++)
      issue_op(OP_BEQ, 1'b1, rob_t'(16 + i), 32'd0, 1'b0, 5'd0, 32'd0, 32'd0, rob_t'(i));
    chk("full_set", 32'(bus.rs_full), 32'd1);
    alu_cdb(5'd25, 32'h99);
    chk("full_wake_hold", 32'(bus.rs_full), 32'd1);
    chk("full_wake_noflag", 32'(bus.out_flag), 32'd0);
    step();
    chk("e9_flag", 32'(bus.out_flag), 32'd1);
    chk("e9_rob",  32'(bus.out_rob_id), 32'd9);
    chk("e9_V1",   bus.out_V1, 32'h99);
    chk("e9_full_drop", 32'(bus.rs_full), 32'd0);
    issue_op(OP_JAL, 1'b1, 5'd30, 32'd0, 1'b0, 5'd0, 32'd0, 32'd0, 5'd20);
    chk("refill_full", 32'(bus.rs_full), 32'd1);
    // Wake refill (tag 30) and entry 10 (tag 26) together: entry 9 must go first.
    bus.alu_cdb_flag = 1'b1; bus.alu_cdb_rob_id = 5'd30; bus.alu_cdb_res = 32'h1;
    bus.lsb_cdb_flag = 1'b1; bus.lsb_cdb_rob_id = 5'd26; bus.lsb_cdb_res = 32'h2;
    step();
    clr_in();
    step();
    chk("refill_in_e9", 32'(bus.out_rob_id), 32'd20);
    step();
    chk("then_e10", 32'(bus.out_rob_id), 32'd10);
    flush();
    chk("flush1_full", 32'(bus.rs_full), 32'd0);
    chk("flush1_flag", 32'(bus.out_flag), 32'd0);

    // Entries 2 and 5 ready in the same cycle.
    for (int i = 0; i < 6; i++)
      issue_op(OP_ADD, 1'b1, rob_t'(10 + i), 32'd0, 1'b0, 5'd0, 32'd0, 32'd0, rob_t'(i));
    bus.alu_cdb_flag = 1'b1; bus.alu_cdb_rob_id = 5'd12; bus.alu_cdb_res = 32'h22;
    bus.lsb_cdb_flag = 1'b1; bus.lsb_cdb_rob_id = 5'd15; bus.lsb_cdb_res = 32'h55;
    step();
    clr_in();
    step();
    chk("prio_first",  32'(bus.out_rob_id), 32'd2);
    chk("prio_first_V1", bus.out_V1, 32'h22);
    step();
    chk("prio_second", 32'(bus.out_rob_id), 32'd5);
    chk("prio_second_flag", 32'(bus.out_flag), 32'd1);
    step();
    chk("prio_done", 32'(bus.out_flag), 32'd0);
    flush();

    // Rollback with 8 busy entries and entry 3 about to dispatch.
    for (int i = 0; i < 8; i++)
      issue_op(OP_ADD, 1'b1, rob_t'(i), 32'd0, 1'b0, 5'd0, 32'd0, 32'd0, rob_t'(16 + i));
    alu_cdb(5'd3, 32'h33);
    flush();
    chk("rb_flag", 32'(bus.out_flag), 32'd0);
    chk("rb_full", 32'(bus.rs_full), 32'd0);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      alu_cdb(rob_t'(i), 32'h40);
      if (bus.out_flag) seen++;
    end
    step();
    if (bus.out_flag) seen++;
    chk("rb_no_stale_dispatch", 32'(seen), 32'd0);

    // rdy low holds state and drops both dispatch and issue.
    issue_op(OP_ADD, 1'b0, 5'd0, 32'h77, 1'b0, 5'd0, 32'd0, 32'd0, 5'd1);
    rdy = 1'b0;
    set_issue(OP_ADD, 1'b0, 5'd0, 32'h88, 1'b0, 5'd0, 32'd0, 32'd0, 5'd2);
    step();
    bus.issue_flag = 1'b0;
    chk("rdy0_flag", 32'(bus.out_flag), 32'd0);
    step();
    chk("rdy0_flag2", 32'(bus.out_flag), 32'd0);
    rdy = 1'b1;
    step();
    chk("rdy1_flag", 32'(bus.out_flag), 32'd1);
    chk("rdy1_V1",   bus.out_V1, 32'h77);
    step();
    chk("rdy0_issue_dropped", 32'(bus.out_flag), 32'd0);

    // Async reset mid-cycle clears outputs and entries without a clock edge.
    issue_op(OP_ADD, 1'b1, 5'd9, 32'd0, 1'b0, 5'd0, 32'd0, 32'd0, 5'd8);
    issue_op(OP_ADD, 1'b0, 5'd0, 32'h55, 1'b0, 5'd0, 32'd0, 32'd0, 5'd7);
    step();
    chk("pre_rst_V1", bus.out_V1, 32'h55);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_flag", 32'(bus.out_flag), 32'd0);
    chk("arst_V1",   bus.out_V1, 32'd0);
    chk("arst_rob",  32'(bus.out_rob_id), 32'd0);
    chk("arst_full", 32'(bus.rs_full), 32'd0);
    #2 rst_n = 1'b1;
    alu_cdb(5'd9, 32'h9);
    step();
    chk("arst_no_stale", 32'(bus.out_flag), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
